pc_unit: RTL

//   Program-counter stage of the single-cycle MIPS core. Holds the PC that

---
 rtl/pc_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter stage with RUN/HALT control for the single-cycle MIPS core.
// Optional performance counters are enabled by defining PC_PERF_EN.
module pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        go,
  input  logic        jump,
  input  logic        branch,
  input  logic        bneorbeq,
  input  logic        isjr,
  input  logic        issyscall,
  input  logic        equal,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  input  logic [31:0] v0_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
`ifdef PC_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
  output logic [31:0] taken_cnt,
`endif
  output logic        halted,
  output logic        retire
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] branch_off;
  logic        branch_taken;
  logic        redirect;

  assign pc_plus4     = pc + 32'd4;
  assign branch_off   = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_taken = branch & (bneorbeq ? ~equal : equal);
  assign halted       = (state == HALT);
  assign retire       = (state == RUN) & ~stall;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    redirect   = 1'b0;
    case (state)
      RUN: begin
        if (!stall) begin
          // A halting syscall keeps pc on itself so resume can step past it.
          if (issyscall && (v0_data == HALT_CODE)) begin
            state_next = HALT;
          end else if (isjr) begin
            pc_next  = rs_data;
            redirect = 1'b1;
          end else if (jump) begin
            pc_next  = {pc_plus4[31:28], target26, 2'b00};
            redirect = 1'b1;
          end else if (branch_taken) begin
            pc_next  = pc_plus4 + branch_off;
            redirect = 1'b1;
          end else begin
            pc_next = pc_plus4;
          end
        end
      end
      HALT: begin
        if (go) begin
          pc_next    = pc_plus4;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

`ifdef PC_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
      taken_cnt <= 32'd0;
    end else begin
      if (state == RUN) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
      if (retire && redirect) taken_cnt <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule
